tube_scan: RTL



---
 rtl/tube_pkg.sv | 18 +
 rtl/tube_scan_hex2seg.sv | 11 +
 rtl/tube_scan.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tube_pkg.sv
// Shared constants for the tube_scan display path: digit count,
// blanking values and the hex-to-seven-segment pattern table.
package tube_pkg;

  localparam int NUM_DIGITS = 8;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Active-low patterns ordered {g,f,e,d,c,b,a}, indexed by hex value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/tube_scan_hex2seg.sv
// Combinational hex digit to active-low seven-segment decoder.
module hex2seg
  import tube_pkg::*;
(
  input  digit_t     digit_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[digit_i];

endmodule

// File: rtl/tube_scan.sv
// Frame-snapshotting 8-digit seven-segment scanner.
// Define TUBE_LZB_EN to enable leading-zero blanking.
module tube_scan
  import tube_pkg::*;
#(
  parameter int DIV   = 100000,
  parameter int Width = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] q7,
  input  logic [Width-1:0] q6,
  input  logic [Width-1:0] q5,
  input  logic [Width-1:0] q4,
  input  logic [Width-1:0] q3,
  input  logic [Width-1:0] q2,
  input  logic [Width-1:0] q1,
  input  logic [Width-1:0] q0,
  input  logic [7:0]       den,
  output logic [7:0]       an,
  output logic [6:0]       seg,
  output logic             frame
);

  localparam int             CW      = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DIV - 1);

  logic [Width-1:0] qLive  [NUM_DIGITS];
  logic [Width-1:0] snap_q [NUM_DIGITS];
  logic [Width-1:0] snap_d [NUM_DIGITS];
  logic [7:0]       den_q, den_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             first_q, first_d;
  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             frame_q, frame_d;
  logic             cntWrap, load, digitDark;
  logic [6:0]       segDec;

  assign qLive[0] = q0;
  assign qLive[1] = q1;
  assign qLive[2] = q2;
  assign qLive[3] = q3;
  assign qLive[4] = q4;
  assign qLive[5] = q5;
  assign qLive[6] = q6;
  assign qLive[7] = q7;

  hex2seg u_hex2seg (
    .digit_i(snap_q[idx_q]),
    .seg_o  (segDec)
  );

`ifdef TUBE_LZB_EN
  logic [7:0] blank_q, blank_d;
  logic       leading;

  // A zero stays blank only while every digit above it is zero or disabled
  always_comb begin
    blank_d = '0;
    leading = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      blank_d[i] = leading && (qLive[i] == '0);
      leading    = leading && ((qLive[i] == '0) || !den[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blank_q <= '0;
    end else if (load) begin
      blank_q <= blank_d;
    end
  end

  assign digitDark = !den_q[idx_q] || blank_q[idx_q];
`else
  assign digitDark = !den_q[idx_q];
`endif

  always_comb begin
    cntWrap = (cnt_q == CNT_MAX);
    load    = first_q || (cntWrap && (idx_q == 3'd7));
    cnt_d   = cntWrap ? '0 : cnt_q + CW'(1);
    idx_d   = cntWrap ? idx_q + 3'd1 : idx_q;
    first_d = 1'b0;
    frame_d = load;
    den_d   = load ? den : den_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      snap_d[i] = load ? qLive[i] : snap_q[i];
    end
    // Slot start is always dark so the anode switch never shows the old digit
    an_d  = (cnt_q == '0 || digitDark) ? AN_OFF : ~(8'd1 << idx_q);
    seg_d = digitDark ? SEG_OFF : segDec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b1;
      den_q   <= '0;
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= first_d;
      den_q   <= den_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule
